// File: rtl/datapath_pkg.sv
// Shared opcode encoding and widths for the load/ALU pipeline.
package datapath_pkg;

   localparam int OPW = 3;

   typedef enum logic [OPW-1:0] {
      OP_ADD   = 3'b000,
      OP_SUB   = 3'b001,
      OP_AND   = 3'b010,
      OP_OR    = 3'b011,
      OP_XOR   = 3'b100,
      OP_MINU  = 3'b101,
      OP_MAXU  = 3'b110,
      OP_PASSA = 3'b111
   } opcode_e;

endpackage

// File: rtl/datapath_if.sv
// Operand/result handshake bundle: master is the producer/consumer side, slave is the pipeline.
interface datapath_if #(
   parameter int WIDTH = 8
);
   logic                          ld;
   logic                          in_ready;
   logic [datapath_pkg::OPW-1:0]  op;
   logic [WIDTH-1:0]              A;
   logic [WIDTH-1:0]              B;
   logic                          out_ready;
   logic                          out_valid;
   logic [WIDTH-1:0]              outA;
   logic [WIDTH-1:0]              outB;
   logic [WIDTH-1:0]              outC;
   logic                          carry;
   logic                          ovf;

   modport master (
      output ld, op, A, B, out_ready,
      input  in_ready, out_valid, outA, outB, outC, carry, ovf
   );

   modport slave (
      input  ld, op, A, B, out_ready,
      output in_ready, out_valid, outA, outB, outC, carry, ovf
   );
endinterface

// File: rtl/datapath_alu.sv
// Combinational ALU with unsigned carry/borrow and signed overflow flags.
// Define DATAPATH_SAT_EN to clamp ADD/SUB to the signed range on overflow.
module datapath_alu
   import datapath_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  opcode_e          op,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             ovf
);

   logic [WIDTH:0]          sum_w;
   logic [WIDTH:0]          dif_w;
   logic                    add_ovf;
   logic                    sub_ovf;
   logic signed [WIDTH-1:0] add_res;
   logic signed [WIDTH-1:0] sub_res;

   assign sum_w   = {1'b0, a} + {1'b0, b};
   assign dif_w   = {1'b0, a} - {1'b0, b};
   // Overflow iff the result sign disagrees with what the operand signs force.
   assign add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1]);
   assign sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif_w[WIDTH-1] != a[WIDTH-1]);

`ifdef DATAPATH_SAT_EN
   // On overflow the true result has the sign of a, so clamp toward that side.
   function automatic logic signed [WIDTH-1:0] sat_fn(
      input logic signed [WIDTH-1:0] raw,
      input logic                    ov,
      input logic                    neg
   );
      logic signed [WIDTH-1:0] lim;
      lim = {neg, {(WIDTH-1){~neg}}};
      return ov ? lim : raw;
   endfunction

   assign add_res = sat_fn(sum_w[WIDTH-1:0], add_ovf, a[WIDTH-1]);
   assign sub_res = sat_fn(dif_w[WIDTH-1:0], sub_ovf, a[WIDTH-1]);
`else
   assign add_res = sum_w[WIDTH-1:0];
   assign sub_res = dif_w[WIDTH-1:0];
`endif

   always_comb begin
      result = '0;
      carry  = 1'b0;
      ovf    = 1'b0;
      case (op)
         OP_ADD: begin
            result = add_res;
            carry  = sum_w[WIDTH];
            ovf    = add_ovf;
         end
         OP_SUB: begin
            result = sub_res;
            carry  = dif_w[WIDTH];
            ovf    = sub_ovf;
         end
         OP_AND:   result = a & b;
         OP_OR:    result = a | b;
         OP_XOR:   result = a ^ b;
         OP_MINU:  result = (a < b) ? a : b;
         OP_MAXU:  result = (a < b) ? b : a;
         OP_PASSA: result = a;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/datapath_pipe.sv
// Two-stage operand-capture / ALU-result pipeline with valid/ready flow control.
// ALU saturation is selected by the DATAPATH_SAT_EN macro (see datapath_alu).
module datapath_pipe
   import datapath_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic     clk,
   input  logic     clr,
   datapath_if.slave bus
);

   logic             vld_p1_d, vld_p1_q;
   logic [WIDTH-1:0] a_p1_d,   a_p1_q;
   logic [WIDTH-1:0] b_p1_d,   b_p1_q;
   opcode_e          op_p1_d,  op_p1_q;

   logic             vld_p2_d, vld_p2_q;
   logic [WIDTH-1:0] a_p2_d,   a_p2_q;
   logic [WIDTH-1:0] b_p2_d,   b_p2_q;
   logic [WIDTH-1:0] c_p2_d,   c_p2_q;
   logic             cy_p2_d,  cy_p2_q;
   logic             ov_p2_d,  ov_p2_q;

   logic             s2_free;
   logic             in_ready;
   logic             accept;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cy;
   logic             alu_ov;

   assign s2_free  = ~vld_p2_q | bus.out_ready;
   assign in_ready = ~vld_p1_q | s2_free;
   assign accept   = bus.ld & in_ready;

   datapath_alu #(.WIDTH(WIDTH)) u_alu (
      .a      (a_p1_q),
      .b      (b_p1_q),
      .op     (op_p1_q),
      .result (alu_res),
      .carry  (alu_cy),
      .ovf    (alu_ov)
   );

   always_comb begin
      vld_p1_d = vld_p1_q;
      a_p1_d   = a_p1_q;
      b_p1_d   = b_p1_q;
      op_p1_d  = op_p1_q;
      vld_p2_d = vld_p2_q;
      a_p2_d   = a_p2_q;
      b_p2_d   = b_p2_q;
      c_p2_d   = c_p2_q;
      cy_p2_d  = cy_p2_q;
      ov_p2_d  = ov_p2_q;

      // Stage 1: operand capture; a simultaneous advance and accept keeps S1 full.
      if (accept) begin
         vld_p1_d = 1'b1;
         a_p1_d   = bus.A;
         b_p1_d   = bus.B;
         op_p1_d  = opcode_e'(bus.op);
      end else if (s2_free) begin
         vld_p1_d = 1'b0;
      end

      // Stage 2: data only loads for a real item so idle outputs stay quiet.
      if (s2_free) begin
         vld_p2_d = vld_p1_q;
         if (vld_p1_q) begin
            a_p2_d  = a_p1_q;
            b_p2_d  = b_p1_q;
            c_p2_d  = alu_res;
            cy_p2_d = alu_cy;
            ov_p2_d = alu_ov;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         a_p2_q   <= '0;
         b_p2_q   <= '0;
         c_p2_q   <= '0;
         cy_p2_q  <= 1'b0;
         ov_p2_q  <= 1'b0;
      end else begin
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         a_p2_q   <= a_p2_d;
         b_p2_q   <= b_p2_d;
         c_p2_q   <= c_p2_d;
         cy_p2_q  <= cy_p2_d;
         ov_p2_q  <= ov_p2_d;
      end
      a_p1_q  <= a_p1_d;
      b_p1_q  <= b_p1_d;
      op_p1_q <= op_p1_d;
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = vld_p2_q;
   assign bus.outA      = a_p2_q;
   assign bus.outB      = b_p2_q;
   assign bus.outC      = c_p2_q;
   assign bus.carry     = cy_p2_q;
   assign bus.ovf       = ov_p2_q;

endmodule

// File: doc/datapath_pipe.md
Name: datapath_pipe

Overview:
Parametrised successor to the team's two-register load/clear datapath. It captures operands A and B on a load strobe and computes a selectable ALU result. The result passes through a 2-stage pipeline with valid/ready flow control, so it can sit between a producer and a stalling consumer. It also reports carry and signed overflow.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
OPW, 3, opcode width (fixed encoding below; must be 3)

Ports:
clk  input  1  system clock, rising edge
clr  input  1  synchronous active-high reset/clear
ld  input  1  operand load request (valid-in)
in_ready  output  1  block can accept ld this cycle
op  input  OPW  operation select, sampled with ld
A  input  WIDTH  operand A
B  input  WIDTH  operand B
out_ready  input  1  consumer accepts result this cycle
out_valid  output  1  outA/outB/outC/flags hold a valid result
outA  output  WIDTH  registered operand A aligned with outC
outB  output  WIDTH  registered operand B aligned with outC
outC  output  WIDTH  ALU result
carry  output  1  ADD carry-out / SUB borrow
ovf  output  1  signed overflow (ADD/SUB only)

Behaviour:
- One clock, clk. Reset clr is synchronous and active-high; it has priority over all other inputs.
- On clr: both stage valids = 0; outA, outB, outC = 0; carry = ovf = 0; out_valid = 0. A transfer in flight is discarded (no partial result escapes).
- Stage 1 (S1) registers A, B, op on accept. Accept = ld & in_ready.
- Stage 2 (S2) registers the computed result, operands and flags. S2 drives the outputs directly.
- S1 advances when s2_free = ~s2_valid | out_ready.
- in_ready = ~s1_valid | s2_free (combinational, no dependency on ld).
- Latency: accepted on edge N gives out_valid=1 after edge N+1. Throughput is 1 per cycle with out_ready held at 1.
- If out_ready=0 and out_valid=1, S2 holds all outputs stable. With S1 also full, in_ready=0. ld is ignored when in_ready=0 (no capture, no error).
- Simultaneous accept and advance in the same cycle is legal; no bubble is inserted.
- Opcodes:
  - 000 ADD: A+B; carry = bit WIDTH of the sum.
  - 001 SUB: A-B; carry = borrow (A<B unsigned).
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 MINU: unsigned min.
  - 110 MAXU: unsigned max.
  - 111 PASSA.
- ovf = signed overflow of ADD/SUB in two's complement. carry = ovf = 0 for all other opcodes.
- Results wrap modulo 2^WIDTH unless the optional feature is enabled.

Optional Feature:
DATAPATH_SAT_EN
- Defined: ADD/SUB saturate in signed two's complement. On overflow, outC = max positive (0111..1) or min negative (1000..0). ovf still reports that the overflow occurred. carry is unchanged (raw unsigned carry/borrow).
- Undefined: wrap-around results; no saturation logic is synthesised.

Decomposition:
- Package datapath_pkg: opcode constants OP_ADD..OP_PASSA, opcode enum typedef, localparam OPW=3.
- Sub-module datapath_alu: purely combinational, parameterised by WIDTH. Inputs a, b, op; outputs result, carry, ovf, with saturation under DATAPATH_SAT_EN.
- datapath_pipe holds only pipeline registers and handshake logic.

Test Plan:
- WIDTH=8, out_ready=1, ld A=9 B=2 op=ADD -> two cycles later out_valid=1, outA=9, outB=2, outC=11, carry=0, ovf=0.
- Back-to-back ADD loads: A=230,B=255 / A=253,B=30 / A=100,B=100 -> outC=229 c=1 o=0 / outC=27 c=1 o=0 / outC=200 c=0 o=1. With DATAPATH_SAT_EN the third gives outC=127, ovf=1.
- SUB A=3 B=5 -> outC=254, carry=1, ovf=0. MINU A=200 B=7 -> 7. MAXU -> 200. XOR 0xF0^0x3C -> 0xCC.
- Backpressure: out_ready=0, three consecutive ld cycles -> first two accepted, in_ready=0 on the third. Outputs hold the first result. Raising out_ready -> results drain in order, none lost or duplicated.
- clr asserted while both stages are valid -> next edge: out_valid=0, outputs 0, in_ready=1. A ld on that same cycle is not captured.
- Random op/A/B, random out_ready, 10k cycles -> outputs match the reference model in order. Outputs stay stable while out_valid & ~out_ready.
